// File: rtl/banked_ram.sv
// Parametrised banked data memory with per-byte write enables, a registered
// read port with valid strobe, and a post-reset sequencer that zeroes every word.
module banked_ram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int BANK_BITS = 2,
  parameter int BYTE_W    = 8,
  localparam int NBE      = DATA_W / BYTE_W,
  localparam int NBANK    = 1 << BANK_BITS
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              en,
  input  logic              WR,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Din,
  input  logic [NBE-1:0]    BE,
  output logic              Ready,
  output logic [DATA_W-1:0] Dout,
  output logic              Dout_valid,
  output logic [NBANK-1:0]  Bank_hit,
  output logic              Drop,
  output logic              dbg_state
);

  localparam int LOCAL_W = ADDR_W - BANK_BITS;
  localparam int DEPTH   = 1 << LOCAL_W;

  typedef enum logic {S_INIT = 1'b0, S_IDLE = 1'b1} state_t;

  // Handshake: there is no back-pressure on the request side. A request is
  // accepted on any rising edge where en=1 and Ready=1; otherwise it is
  // dropped (Drop pulses next cycle). A read accepted at edge N presents its
  // data on Dout with Dout_valid=1 for exactly the cycle after edge N.

  state_t              state_q, state_d;
  logic [LOCAL_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic [NBANK-1:0]    bank_hit_q, bank_hit_d;
  logic                drop_q, drop_d;

  logic [DATA_W-1:0]    mem [NBANK][DEPTH];
  logic [BANK_BITS-1:0] bank;
  logic [LOCAL_W-1:0]   loc;
  logic                 ready;
  logic                 accept;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 init_we;
  logic [DATA_W-1:0]    rd_word;

  assign bank    = Address[ADDR_W-1 -: BANK_BITS];
  assign loc     = Address[LOCAL_W-1:0];
  assign ready   = (state_q == S_IDLE);
  assign accept  = en & ready;
  assign wr_acc  = accept & WR;
  assign rd_acc  = accept & ~WR;
  assign init_we = (state_q == S_INIT) & ~Rst;
  assign rd_word = mem[bank][loc];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = rd_acc;
    bank_hit_d   = bank_hit_q;
    drop_d       = en & ~ready;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LOCAL_W'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: ;
      default: state_d = S_INIT;
    endcase
    if (rd_acc) dout_d = rd_word;
    if (accept) bank_hit_d = NBANK'(1) << bank;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      bank_hit_q   <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      bank_hit_q   <= bank_hit_d;
      drop_q       <= drop_d;
    end
  end

  // Init clears the same local index in every bank at once; user writes touch
  // only the selected bank and only its enabled byte lanes.
  always_ff @(posedge Clk) begin
    for (int b = 0; b < NBANK; b++) begin
      if (init_we) begin
        mem[b][cnt_q] <= '0;
      end else if (wr_acc && (bank == BANK_BITS'(b))) begin
        for (int i = 0; i < NBE; i++) begin
          if (BE[i]) mem[b][loc][i*BYTE_W +: BYTE_W] <= Din[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign Ready      = ready;
  assign Dout       = dout_q;
  assign Dout_valid = dout_valid_q;
  assign Bank_hit   = bank_hit_q;
  assign Drop       = drop_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_banked_ram.sv
// Self-checking bench for banked_ram: directed scenarios plus random traffic,
// every cycle compared against a word-array reference model.
module tb_banked_ram;

  localparam int DEPTH = 64;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        en = 1'b0;
  logic        WR = 1'b0;
  logic [7:0]  Address = '0;
  logic [31:0] Din = '0;
  logic [3:0]  BE = '0;
  logic        Ready;
  logic [31:0] Dout;
  logic        Dout_valid;
  logic [3:0]  Bank_hit;
  logic        Drop;
  logic        dbg_state;

  banked_ram dut (
    .Clk(Clk), .Rst(Rst), .en(en), .WR(WR), .Address(Address), .Din(Din),
    .BE(BE), .Ready(Ready), .Dout(Dout), .Dout_valid(Dout_valid),
    .Bank_hit(Bank_hit), .Drop(Drop), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // reference model state
  logic [31:0] ref_mem [256];
  int          init_left;
  logic [31:0] m_dout;
  logic        m_valid;
  logic [3:0]  m_hit;
  logic        m_drop;
  logic [31:0] exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance model by the documented rules, compare.
  task automatic step(input logic rst, input logic e, input logic w,
                      input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge Clk);
    Rst = rst; en = e; WR = w; Address = a; Din = d; BE = b;
    @(posedge Clk);
    if (rst) begin
      init_left = DEPTH;
      m_valid = 1'b0; m_dout = '0; m_hit = '0; m_drop = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 256; k++) ref_mem[k] = '0;
    end else if (init_left > 0) begin
      init_left--;
      m_drop = e;
      m_valid = 1'b0;
    end else begin
      m_drop = 1'b0;
      m_valid = 1'b0;
      if (e) begin
        m_hit = 4'b0001 << a[7:6];
        if (w) begin
          for (int i = 0; i < 4; i++)
            if (b[i]) ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
        end else begin
          exp_q.push_back(ref_mem[a]);
          m_valid = 1'b1;
        end
      end
    end
    if (m_valid && exp_q.size() > 0) m_dout = exp_q.pop_front();
    #1;
    check("ready", {31'b0, Ready}, {31'b0, (init_left == 0)});
    check("valid", {31'b0, Dout_valid}, {31'b0, m_valid});
    check("dout", Dout, m_dout);
    check("bank_hit", {28'b0, Bank_hit}, {28'b0, m_hit});
    check("drop", {31'b0, Drop}, {31'b0, m_drop});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    step(1'b0, 1'b1, 1'b1, a, d, b);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b0, 1'b1, 1'b0, a, 32'h0, 4'hF);
  endtask

  // hard bound on total runtime
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ra;
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    check("reset_state", {31'b0, dbg_state}, 32'd0);

    // init window with a dropped write attempt
    idle(3);
    wr(8'h00, 32'hFFFF_FFFF, 4'hF);
    idle(DEPTH - 4);
    check("init_state", {31'b0, dbg_state}, 32'd1);
    rd(8'h00); rd(8'h3F); rd(8'h40); rd(8'hFF); idle(1);

    // cross-bank readback
    wr(8'h05, 32'hDEAD_BEEF, 4'hF);
    wr(8'hC5, 32'h1234_5678, 4'hF);
    rd(8'h05); rd(8'hC5); idle(1);

    // byte lanes
    wr(8'h10, 32'hFFFF_FFFF, 4'hF);
    wr(8'h10, 32'h00AA_0055, 4'b0101);
    wr(8'h10, 32'h1234_5678, 4'h0);
    rd(8'h10); idle(1);
    check("byte_merge", Dout, 32'hFFAA_FF55);

    // read-after-write and back-to-back reads
    wr(8'h80, 32'hCAFE_F00D, 4'hF);
    rd(8'h80); rd(8'h05); rd(8'hC5); idle(2);

    // reset during a read
    wr(8'h20, 32'h1111_1111, 4'hF);
    step(1'b1, 1'b1, 1'b0, 8'h20, 32'h0, 4'hF);
    idle(DEPTH);
    rd(8'h20); idle(1);

    // random traffic over a small hot set plus the full range
    for (int c = 0; c < 600; c++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'({$urandom_range(0, 3), 6'h0} | $urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0)
        step(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
      else
        step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra,
             $urandom, 4'($urandom_range(0, 15)));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/banked_ram.md
Name: banked_ram

Overview:
Parametrised successor to the fixed 4-bank, 32-bit banked RAM. Word width, address width, bank count and byte-lane granularity are all parameters. Adds per-byte write enables, a registered read with a valid strobe, and a self-clearing init sequencer that zeroes every location after reset. It sits behind the datapath/CPU load-store port as general-purpose data memory.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of BYTE_W
ADDR_W, 8, word address width
BANK_BITS, 2, number of address MSBs used as bank select; NBANK = 2^BANK_BITS
BYTE_W, 8, byte-lane width; NBE = DATA_W/BYTE_W
Derived: DEPTH = 2^(ADDR_W-BANK_BITS) words per bank.

Ports:
Clk  input  1  clock, all logic on rising edge
Rst  input  1  synchronous reset, active-high
en  input  1  access request
WR  input  1  1 = write, 0 = read; sampled with en
Address  input  ADDR_W  word address; [ADDR_W-1 -: BANK_BITS] = bank, remaining low bits = local index
Din  input  DATA_W  write data
BE  input  NBE  byte-lane write enables; bit i covers Din[i*BYTE_W +: BYTE_W]
Ready  output  1  1 = accepting requests (init complete)
Dout  output  DATA_W  registered read data
Dout_valid  output  1  one-cycle strobe, Dout holds new read data
Bank_hit  output  NBANK  registered one-hot of the bank touched by the last accepted access
Drop  output  1  one-cycle pulse: request presented while Ready=0

Behaviour:
- Clock Clk; reset Rst is synchronous and active-high. All state updates on the Clk rising edge.
- Reset values: state=INIT, init counter=0, Ready=0, Dout=0, Dout_valid=0, Bank_hit=0, Drop=0.
- State machine: INIT -> IDLE only. Rst from any state returns to INIT.
- INIT: every cycle, write all-zero to local index = counter in every bank, then increment the counter. On the cycle the counter = DEPTH-1 is written, go to IDLE.
- Ready=1 exactly in IDLE. Ready rises DEPTH cycles after the first cycle with Rst low.
- Accept = en & Ready. Non-accepted cycles: Dout_valid=0, Dout holds its value, Bank_hit holds its value, memory unchanged.
- Write accept: in the selected bank only, each byte lane with BE[i]=1 is updated at that edge; lanes with BE[i]=0 are unchanged. BE=0 is a legal no-op write, but Bank_hit still updates. Next cycle Dout_valid=0 and Dout is unchanged.
- Read accept: read latency 1. On the next edge, Dout = mem[bank][local] and Dout_valid=1 for one cycle. BE is ignored on reads.
- Back-to-back reads: a new Dout/Dout_valid every cycle, no bubbles.
- Write then read of the same address on consecutive cycles: the read returns the new data.
- Bank_hit: registered one-hot of the accessed bank, updated on every accepted access. It is 0 after reset until the first accept.
- Drop: registered; Drop=1 on the cycle after en=1 while Ready=0 and Rst=0. Requests during INIT never modify memory and never raise Dout_valid.
- Rst mid-operation: any pending Dout_valid is suppressed (0 on the cycle after Rst), memory is re-zeroed, and the init counter restarts at 0. Rst dominates en.
- Address space is fully decoded; no out-of-range case exists.
- Memory inferred as one array per bank, or a single array indexed {bank,local}. No tristates; the output is a mux/register.

Test Plan:
- Init: assert Rst 2 cycles, release. Ready=0 for 64 cycles, then Ready=1. Reading addresses 0x00, 0x3F, 0x40, 0xFF gives Dout=0x00000000 with Dout_valid one cycle after each accept.
- Write/readback across banks: write 0xDEADBEEF @0x05 and 0x12345678 @0xC5, both with BE=4'hF. Reading 0x05 gives 0xDEADBEEF with Bank_hit=4'b0001. Reading 0xC5 gives 0x12345678 with Bank_hit=4'b1000.
- Byte enables: write 0xFFFFFFFF @0x10 with BE=4'hF, then 0x00AA0055 @0x10 with BE=4'b0101. Readback gives 0xFFAAFF55.
- Pipelining/RAW: write 0xCAFEF00D @0x80, then next cycle read 0x80. Dout=0xCAFEF00D with Dout_valid=1 on the following cycle. Three consecutive reads give three consecutive valid strobes.
- Drop/INIT protection: en=1, WR=1, Din=0xFFFFFFFF @0x00 during INIT. Drop pulses, and a later read of 0x00 returns 0.
- Reset mid-run: write 0x11111111 @0x20, issue a read, and assert Rst on the same cycle. Dout_valid stays 0 and Ready drops. After re-init, a read of 0x20 returns 0.
